// File: rtl/seven_seg_display_ctrl.sv
// Multi-digit seven-segment controller: hex or decimal (double-dabble) display with
// leading-zero blanking, overflow dashes, per-digit blink and decimal points.
module seven_seg_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = 20,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [VALUE_W-1:0]        value,
    input  logic                      hex_mode,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic                      ready,
    output logic [8*NUM_DIGITS-1:0]   segs
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IW = $clog2(VALUE_W + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                          state;
    logic [VALUE_W-1:0]              val_q;
    logic [VALUE_W-1:0]              sh_q;
    logic                            hex_q;
    logic                            blz_q;
    logic [DW-1:0]                   bcd_q;
    logic [IW-1:0]                   iter_q;
    logic [NUM_DIGITS-1:0][6:0]      glyph_q;
    logic [CW-1:0]                   blink_cnt;
    logic                            phase;

    logic [DW-1:0]                   bcd_adj;
    logic [DW+VALUE_W-1:0]           ext;
    logic                            ovf;
    logic                            lead;
    logic [DW-1:0]                   nibbles;
    logic [NUM_DIGITS-1:0][6:0]      new_glyph;
    logic [NUM_DIGITS-1:0][6:0]      disp;
    logic [8*NUM_DIGITS-1:0]         segs_next;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Digits are resolved from the top down so blanking stops at the first nonzero digit.
    always_comb begin
        ext       = (DW + VALUE_W)'(val_q);
        ovf       = hex_q ? ((ext >> DW) != '0) : (64'(val_q) >= DEC_LIMIT);
        nibbles   = hex_q ? ext[DW-1:0] : bcd_q;
        lead      = blz_q;
        new_glyph = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (ovf) begin
                new_glyph[NUM_DIGITS-1-k] = 7'h3F;
            end else if (lead && (nibbles[4*(NUM_DIGITS-1-k) +: 4] == 4'd0) && (k != NUM_DIGITS - 1)) begin
                new_glyph[NUM_DIGITS-1-k] = 7'h7F;
            end else begin
                new_glyph[NUM_DIGITS-1-k] = glyph(nibbles[4*(NUM_DIGITS-1-k) +: 4]);
                lead = 1'b0;
            end
        end
    end

    always_comb begin
        disp      = (state == UPDATE) ? new_glyph : glyph_q;
        segs_next = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!(phase && blink_mask[i])) segs_next[8*i +: 8] = {~dp_mask[i], disp[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            glyph_q <= '1;
            val_q   <= '0;
            sh_q    <= '0;
            hex_q   <= 1'b0;
            blz_q   <= 1'b0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        val_q <= value;
                        sh_q  <= value;
                        hex_q <= hex_mode;
                        blz_q <= blank_lz;
                        ready <= 1'b0;
                        if (hex_mode) begin
                            state <= UPDATE;
                        end else begin
                            bcd_q  <= '0;
                            iter_q <= '0;
                            state  <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    bcd_q  <= {bcd_adj[DW-2:0], sh_q[VALUE_W-1]};
                    sh_q   <= {sh_q[VALUE_W-2:0], 1'b0};
                    iter_q <= iter_q + IW'(1);
                    if (iter_q == IW'(VALUE_W - 1)) state <= UPDATE;
                end
                UPDATE: begin
                    glyph_q <= new_glyph;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) segs <= '1;
        else     segs <= segs_next;
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed and randomized checks of seven_seg_display_ctrl against an arithmetic display model.
module tb_seven_seg_display_ctrl;

    localparam int unsigned ND = 6;
    localparam int unsigned VW = 20;
    localparam int unsigned BD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [VW-1:0]     value = '0;
    logic              hex_mode = 1'b0;
    logic              blank_lz = 1'b0;
    logic [ND-1:0]     blink_mask = '0;
    logic [ND-1:0]     dp_mask = '0;
    logic              ready;
    logic [8*ND-1:0]   segs;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seven_seg_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .dp_mask(dp_mask),
        .ready(ready), .segs(segs)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the display after edge n reflects the phase held before edge n.
    always @(posedge clk) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic bit exp_phase();
        return bit'(((ncyc - 1) / BD) % 2);
    endfunction

    function automatic logic [8*ND-1:0] model(input int unsigned v, input bit h, input bit b,
                                              input logic [ND-1:0] bm, input logic [ND-1:0] dm,
                                              input bit ph);
        logic [8*ND-1:0] r;
        logic [7:0]      g;
        longint unsigned base, p, lim, hi;
        bit              ovf;
        base = h ? 16 : 10;
        lim  = 1;
        for (int i = 0; i < ND; i++) lim = lim * base;
        ovf = (longint'(v) >= lim);
        p = 1;
        for (int i = 0; i < ND; i++) begin
            hi = longint'(v) / p;
            if (ovf)                      g = 8'hBF;
            else if (b && i > 0 && hi == 0) g = 8'hFF;
            else                          g = GLYPH[hi % base];
            if (dm[i]) g[7] = 1'b0;
            if (ph && bm[i]) g = 8'hFF;
            r[8*i +: 8] = g;
            p = p * base;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned v, input bit h, input bit b, input bit glitch);
        int n;
        check("ready_idle", 64'(ready), 64'd1);
        value = VW'(v); hex_mode = h; blank_lz = b; load = 1'b1;
        tick();
        load = 1'b0;
        check("ready_busy", 64'(ready), 64'd0);
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            if (glitch && n == 4) begin
                load = 1'b1; value = VW'(777); hex_mode = ~h;
            end
            tick();
            load = 1'b0;
            n++;
        end
        check("latency", 64'(n), h ? 64'd1 : 64'd21);
        check("segs_model", 64'(segs), 64'(model(v, h, b, blink_mask, dp_mask, exp_phase())));
    endtask

    initial begin
        logic [8*ND-1:0] hexexp, decexp;
        int unsigned     v;

        tick(); tick();
        check("rst_segs", 64'(segs), 64'hFFFF_FFFF_FFFF);
        check("rst_ready", 64'(ready), 64'd1);
        rst = 1'b0;
        tick();
        check("post_rst_segs", 64'(segs), 64'hFFFF_FFFF_FFFF);

        do_load(32'h00A3F, 1'b1, 1'b1, 1'b0);
        check("hex_a3f", 64'(segs), 64'hFFFF_FF88_B08E);

        do_load(123456, 1'b0, 1'b0, 1'b1);
        check("dec_123456", 64'(segs), 64'hF9A4_B099_9282);

        do_load(1000000, 1'b0, 1'b0, 1'b0);
        check("dec_ovf", 64'(segs), 64'hBFBF_BFBF_BFBF);
        do_load(999999, 1'b0, 1'b1, 1'b0);
        do_load(0, 1'b0, 1'b1, 1'b0);
        check("dec_zero_lz", 64'(segs), 64'hFFFF_FFFF_FFC0);
        do_load(0, 1'b1, 1'b1, 1'b0);
        do_load((1 << VW) - 1, 1'b1, 1'b0, 1'b0);

        // Reset during conversion blanks immediately.
        value = VW'(999999); hex_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_segs", 64'(segs), 64'hFFFF_FFFF_FFFF);
        check("midrst_ready", 64'(ready), 64'd1);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("after_rst_ready", 64'(ready), 64'd1);
        check("after_rst_segs", 64'(segs), 64'hFFFF_FFFF_FFFF);
        do_load(42, 1'b0, 1'b1, 1'b0);

        // Blink and decimal point on a settled display.
        do_load(123456, 1'b0, 1'b0, 1'b0);
        blink_mask = 6'b000001; dp_mask = 6'b000010;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("blink_segs", 64'(segs), 64'(model(123456, 1'b0, 1'b0, blink_mask, dp_mask, exp_phase())));
            check("blink_dig1", 64'(segs[15:8]), 64'h12);
        end
        blink_mask = '0; dp_mask = '0;
        tick();

        // Back-to-back loads with load held high.
        hexexp = model(32'h1B2C4, 1'b1, 1'b0, '0, '0, 1'b0);
        decexp = model(654321, 1'b0, 1'b1, '0, '0, 1'b0);
        value = VW'(32'h1B2C4); hex_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
        tick();
        value = VW'(654321); hex_mode = 1'b0; blank_lz = 1'b1;
        tick();
        check("b2b_hex_segs", 64'(segs), 64'(hexexp));
        check("b2b_ready_hi", 64'(ready), 64'd1);
        tick();
        check("b2b_capture", 64'(ready), 64'd0);
        load = 1'b0;
        for (int i = 3; i <= 22; i++) begin
            tick();
            check("b2b_hold", 64'({ready, segs}), 64'({1'b0, hexexp}));
        end
        tick();
        check("b2b_dec_segs", 64'(segs), 64'(decexp));
        check("b2b_ready_end", 64'(ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 999) : $urandom_range(0, (1 << VW) - 1);
            dp_mask = ND'($urandom);
            do_load(v, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
